// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Single-precision field widths, normalizer state encoding and
//               the shared exponent adder helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int              EXP_W    = 8;
    localparam int              MANT_W   = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int              EXP_BIAS = 127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    // Modulo-256 exponent step; 8'hFF as the addend gives a decrement.
    function automatic logic [EXP_W-1:0] exponent_adder(input logic [EXP_W-1:0] a,
                                                        input logic [EXP_W-1:0] b);
        return a + b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mantissa_normalizer.sv
// ============================================================================
// Module      : mantissa_normalizer
// Description : Iterative post-addition normalizer producing a packed IEEE-754
//               single with overflow/underflow flags over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mantissa_normalizer
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [MANT_W+1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_overflow,
    output logic                out_underflow
);

    norm_state_t        r_state, w_state_next;
    logic               r_sign, w_sign_next;
    logic [EXP_W-1:0]   r_exp, w_exp_next;
    logic [MANT_W+1:0]  r_mant, w_mant_next;
    logic               r_ovf, w_ovf_next;
    logic               r_unf, w_unf_next;

    logic [EXP_W-1:0]   w_exp_inc;
    logic [EXP_W-1:0]   w_exp_dec;
    logic [MANT_W+1:0]  w_mant_shl;
    fp32_t              w_result;

    assign w_exp_inc  = exponent_adder(r_exp, 8'h01);
    assign w_exp_dec  = exponent_adder(r_exp, 8'hFF);
    assign w_mant_shl = {r_mant[MANT_W:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sign  <= w_sign_next;
            r_exp   <= w_exp_next;
            r_mant  <= w_mant_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sign_next  = r_sign;
        w_exp_next   = r_exp;
        w_mant_next  = r_mant;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_sign_next  = in_sign;
                    w_exp_next   = in_exp;
                    w_mant_next  = in_mant;
                    w_ovf_next   = 1'b0;
                    w_unf_next   = 1'b0;
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_DONE;
                if (r_exp == EXP_MAX) begin
                    w_mant_next = '0;
                    w_ovf_next  = 1'b1;
                end else if (r_mant == '0) begin
                    w_exp_next = '0;
                end else if (r_exp == '0) begin
                    w_mant_next = '0;
                    w_unf_next  = 1'b1;
                end else if (r_mant[MANT_W+1]) begin
                    // Carry out: renormalize right, truncating the dropped LSB.
                    w_exp_next = w_exp_inc;
                    if (w_exp_inc == EXP_MAX) begin
                        w_mant_next = '0;
                        w_ovf_next  = 1'b1;
                    end else begin
                        w_mant_next = r_mant >> 1;
                    end
                end else if (!r_mant[MANT_W]) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Denormals are never produced: exhausting the exponent flushes to zero.
                if (r_exp <= 8'd1) begin
                    w_exp_next   = '0;
                    w_mant_next  = '0;
                    w_unf_next   = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_exp_next  = w_exp_dec;
                    w_mant_next = w_mant_shl;
                    if (w_mant_shl[MANT_W]) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_result.sign = r_sign;
        w_result.exp  = r_exp;
        w_result.frac = r_mant[MANT_W-1:0];
        in_ready      = (r_state == ST_IDLE) && rst_n;
        out_valid     = (r_state == ST_DONE);
        out_result    = w_result;
        out_overflow  = r_ovf;
        out_underflow = r_unf;
    end

endmodule

`default_nettype wire
